// File: rtl/pokey_mixer_dac.sv
// pokey_mixer_dac
//   Final audio stage behind pokeyaudio. It brings the four channel bits and
//   their volumes into the 27 MHz domain, sums the enabled volumes into one
//   6-bit level (0..60) at a fixed sample rate, and drives a single header
//   pin through a 1-bit modulator (first-order sigma-delta or 64-step PWM).
//   It also tracks the peak mixed level for debug.
//
// Ports
//   clk27          27 MHz clock, all logic on its rising edge
//   init_L         asynchronous active-low reset
//   audio1..4      channel bits (foreign clock domain)
//   vol1..4        4-bit channel volumes (foreign clock domain)
//   volOnly        per-channel force bits, bit n-1 = channel n
//   mode           0 = sigma-delta, 1 = PWM
//   mute           forces dac_out low and freezes the modulator state
//   peak_clr       clears the peak meter
//   dac_out        modulated 1-bit audio
//   mix_level      current mixed level, 0..60
//   sample_tick    one-cycle strobe; mix_level and peak carry a new sample
//                  in exactly the cycle this is high (no back-pressure)
//   peak           largest mix_level since reset or the last peak_clr
module pokey_mixer_dac #(
  parameter int SAMPLE_DIV  = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk27,
  input  logic       init_L,
  input  logic       audio1,
  input  logic       audio2,
  input  logic       audio3,
  input  logic       audio4,
  input  logic [3:0] vol1,
  input  logic [3:0] vol2,
  input  logic [3:0] vol3,
  input  logic [3:0] vol4,
  input  logic [3:0] volOnly,
  input  logic       mode,
  input  logic       mute,
  input  logic       peak_clr,
  output logic       dac_out,
  output logic [5:0] mix_level,
  output logic       sample_tick,
  output logic [5:0] peak
);

  localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);

  // ---------------------------------------------------------------------
  // Synchronisers: single-bit controls and the volume buses share depth.
  // ---------------------------------------------------------------------
  logic [10:0] ctl_in;
  logic [10:0] ctl_sync [SYNC_STAGES];
  logic [15:0] vol_in;
  logic [15:0] vol_sync [SYNC_STAGES];

  assign ctl_in = {peak_clr, mute, mode, volOnly, audio4, audio3, audio2, audio1};
  assign vol_in = {vol4, vol3, vol2, vol1};

  always_ff @(posedge clk27 or negedge init_L) begin
    if (!init_L) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ctl_sync[i] <= '0;
        vol_sync[i] <= '0;
      end
    end else begin
      ctl_sync[0] <= ctl_in;
      vol_sync[0] <= vol_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ctl_sync[i] <= ctl_sync[i-1];
        vol_sync[i] <= vol_sync[i-1];
      end
    end
  end

  logic [3:0] aud_s;
  logic [3:0] vo_s;
  logic       mode_s;
  logic       mute_s;
  logic       clr_s;

  assign {clr_s, mute_s, mode_s, vo_s, aud_s} = ctl_sync[SYNC_STAGES-1];

  // Held volumes: a nibble is accepted only when it has been identical in the
  // last two stages, so a bus caught mid-transition never reaches the mixer.
  logic [15:0] volq;

  always_ff @(posedge clk27 or negedge init_L) begin
    if (!init_L) begin
      volq <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (vol_sync[SYNC_STAGES-1][4*n +: 4] == vol_sync[SYNC_STAGES-2][4*n +: 4])
          volq[4*n +: 4] <= vol_sync[SYNC_STAGES-1][4*n +: 4];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Mixer: sum of enabled channel volumes, at most 4 * 15 = 60.
  // ---------------------------------------------------------------------
  logic [5:0] mix_sum;

  always_comb begin
    mix_sum = '0;
    for (int n = 0; n < 4; n++) begin
      if (aud_s[n] | vo_s[n])
        mix_sum = mix_sum + {2'b00, volq[4*n +: 4]};
    end
  end

  // Sample counter, sample strobe, mix register and peak meter.
  logic [7:0] cnt;

  always_ff @(posedge clk27 or negedge init_L) begin
    if (!init_L) begin
      cnt         <= '0;
      sample_tick <= 1'b0;
      mix_level   <= '0;
      peak        <= '0;
    end else begin
      if (cnt == DIV_LAST) begin
        cnt         <= '0;
        sample_tick <= 1'b1;
        mix_level   <= mix_sum;
        // A clear landing on a sample restarts the meter at that sample.
        if (clr_s || (mix_sum > peak))
          peak <= mix_sum;
      end else begin
        cnt         <= cnt + 8'd1;
        sample_tick <= 1'b0;
        if (clr_s)
          peak <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Modulator. The sigma-delta accumulator only needs its low six bits: the
  // carry out of the add is emitted on dac_out and never fed back.
  // ---------------------------------------------------------------------
  logic       mode_prev;
  logic [5:0] acc;
  logic [5:0] pwmcnt;
  logic [5:0] pwmlvl;
  logic [6:0] sd_sum;

  assign sd_sum = {1'b0, acc} + {1'b0, mix_level};

  always_ff @(posedge clk27 or negedge init_L) begin
    if (!init_L) begin
      mode_prev <= 1'b0;
      acc       <= '0;
      pwmcnt    <= '0;
      pwmlvl    <= '0;
      dac_out   <= 1'b0;
    end else begin
      mode_prev <= mode_s;
      if (mode_s != mode_prev) begin
        // One quiet cycle on a mode change; both modulators restart clean.
        acc     <= '0;
        pwmcnt  <= '0;
        pwmlvl  <= mix_level;
        dac_out <= 1'b0;
      end else if (mute_s) begin
        dac_out <= 1'b0;
      end else if (!mode_s) begin
        acc     <= sd_sum[5:0];
        dac_out <= sd_sum[6];
      end else begin
        pwmcnt <= pwmcnt + 6'd1;
        // Duty is only reloaded at the period boundary.
        if (pwmcnt == 6'd63)
          pwmlvl <= mix_level;
        dac_out <= (pwmcnt < pwmlvl);
      end
    end
  end

endmodule

// File: tb/tb_pokey_mixer_dac.sv
// Testbench for pokey_mixer_dac: directed checks of reset, mixing, peak,
// sigma-delta density, PWM shape, mute and mode switching, followed by a
// randomized phase. Every sample strobe is checked against a reference model
// that predicts mix_level and peak from the recorded input history.
module tb_pokey_mixer_dac;

  localparam int SAMPLE_DIV  = 15;
  localparam int SYNC_STAGES = 2;

  logic       clk27 = 1'b0;
  logic       init_L = 1'b0;
  logic       audio1 = 1'b0, audio2 = 1'b0, audio3 = 1'b0, audio4 = 1'b0;
  logic [3:0] vol1 = '0, vol2 = '0, vol3 = '0, vol4 = '0;
  logic [3:0] volOnly = '0;
  logic       mode = 1'b0, mute = 1'b0, peak_clr = 1'b0;
  logic       dac_out;
  logic [5:0] mix_level;
  logic       sample_tick;
  logic [5:0] peak;

  pokey_mixer_dac #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk27      (clk27),
    .init_L     (init_L),
    .audio1     (audio1),
    .audio2     (audio2),
    .audio3     (audio3),
    .audio4     (audio4),
    .vol1       (vol1),
    .vol2       (vol2),
    .vol3       (vol3),
    .vol4       (vol4),
    .volOnly    (volOnly),
    .mode       (mode),
    .mute       (mute),
    .peak_clr   (peak_clr),
    .dac_out    (dac_out),
    .mix_level  (mix_level),
    .sample_tick(sample_tick),
    .peak       (peak)
  );

  // ---------------- clock / reset ----------------
  always #5 clk27 = ~clk27;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and checker ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs are recorded once per clock edge; hist[k] is what edge k sampled.
  // The design sees an input SYNC_STAGES edges late; a volume is believed
  // once it has been the same on two consecutive recorded edges.
  typedef struct packed {
    logic [3:0]  aud;
    logic [3:0]  vo;
    logic [15:0] vol;
    logic        clr;
  } snap_t;

  snap_t       hist[$];
  logic [11:0] exp_q[$];   // {mix_level, peak} expected at each sample strobe
  int          cyc;
  logic [3:0]  vq_m[4];
  int          peak_m;
  int          mix_m;
  snap_t       cur_s, d_s, a_s;

  function automatic snap_t h(input int j);
    if (j < 1 || j >= hist.size()) return '0;
    return hist[j];
  endfunction

  initial begin
    forever begin
      @(posedge clk27);
      if (!init_L) begin
        hist.delete();
        hist.push_back('0);
        exp_q.delete();
        cyc    = 0;
        peak_m = 0;
        for (int n = 0; n < 4; n++) vq_m[n] = '0;
      end else begin
        cyc++;
        cur_s.aud = {audio4, audio3, audio2, audio1};
        cur_s.vo  = volOnly;
        cur_s.vol = {vol4, vol3, vol2, vol1};
        cur_s.clr = peak_clr;
        hist.push_back(cur_s);
        d_s = h(cyc - SYNC_STAGES);
        if (cyc % SAMPLE_DIV == 0) begin
          mix_m = 0;
          for (int n = 0; n < 4; n++)
            if (d_s.aud[n] | d_s.vo[n]) mix_m += int'(vq_m[n]);
          if (d_s.clr || mix_m > peak_m) peak_m = mix_m;
          exp_q.push_back({6'(mix_m), 6'(peak_m)});
        end else if (d_s.clr) begin
          peak_m = 0;
        end
        a_s = h(cyc - SYNC_STAGES + 1);
        for (int n = 0; n < 4; n++)
          if (a_s.vol[4*n +: 4] == d_s.vol[4*n +: 4]) vq_m[n] = d_s.vol[4*n +: 4];
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [11:0] exp_v;

  initial begin
    forever begin
      @(negedge clk27);
      if (init_L && sample_tick) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tick_unexpected: got sample_tick=1, expected no sample at cycle %0d", cyc);
        end else begin
          exp_v = exp_q.pop_front();
          check("tick_mix", int'(mix_level), int'(exp_v[11:6]));
          check("tick_peak", int'(peak), int'(exp_v[5:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk27);
  endtask

  task automatic drive(input logic [3:0] aud, input logic [3:0] vo,
                       input logic [3:0] v1, input logic [3:0] v2,
                       input logic [3:0] v3, input logic [3:0] v4);
    {audio4, audio3, audio2, audio1} = aud;
    volOnly = vo;
    vol1 = v1;
    vol2 = v2;
    vol3 = v3;
    vol4 = v4;
  endtask

  task automatic count_ones(input int n, output int ones, output int same_pairs);
    logic prev;
    ones = 0;
    same_pairs = 0;
    prev = dac_out;
    for (int i = 0; i < n; i++) begin
      @(negedge clk27);
      ones += int'(dac_out);
      if (i > 0 && dac_out == prev) same_pairs++;
      prev = dac_out;
    end
  endtask

  // ---------------- stimulus ----------------
  int first_tick;
  int ones, same;
  int lvl, exp_bit;
  int seg_len;
  logic glitch;

  initial begin
    // Reset held with active inputs.
    drive(4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    cycles(6);
    check("rst_dac_out", int'(dac_out), 0);
    check("rst_mix_level", int'(mix_level), 0);
    check("rst_peak", int'(peak), 0);
    check("rst_sample_tick", int'(sample_tick), 0);
    drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    cycles(2);
    init_L = 1'b1;

    // First strobe after release.
    first_tick = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk27);
      if (sample_tick) begin
        first_tick = i;
        break;
      end
    end
    check("first_tick_cycle", first_tick, SAMPLE_DIV);
    check("first_tick_mix", int'(mix_level), 0);

    // Mixing and peak.
    drive(4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    cycles(40);
    check("mix_all15", int'(mix_level), 60);
    check("peak_all15", int'(peak), 60);
    drive(4'b1011, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    cycles(40);
    check("mix_ch3_off", int'(mix_level), 45);
    check("peak_held", int'(peak), 60);
    peak_clr = 1'b1;
    cycles(1);
    peak_clr = 1'b0;
    cycles(40);
    check("peak_after_clr", int'(peak), 45);

    // Sigma-delta density.
    drive(4'hF, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8);
    cycles(40);
    check("sd_mix32", int'(mix_level), 32);
    count_ones(64, ones, same);
    check("sd32_ones", ones, 32);
    check("sd32_alternate", same, 0);
    drive(4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    cycles(40);
    count_ones(64, ones, same);
    check("sd60_ones", ones, 60);

    // Mute.
    mute = 1'b1;
    cycles(SYNC_STAGES + 1);
    check("mute_dac_zero", int'(dac_out), 0);
    count_ones(20, ones, same);
    check("mute_held_ones", ones, 0);
    check("mute_mix_runs", int'(mix_level), 60);
    mute = 1'b0;
    cycles(5);
    count_ones(64, ones, same);
    check("unmute_sd60_ones", ones, 60);

    // Mode switch into PWM at level 48, then 40 from the third period.
    drive(4'hF, 4'h0, 4'hC, 4'hC, 4'hC, 4'hC);
    cycles(40);
    check("pwm_mix48", int'(mix_level), 48);
    mode = 1'b1;
    cycles(SYNC_STAGES + 1);
    check("mode_switch_zero", int'(dac_out), 0);
    for (int p = 1; p <= 192; p++) begin
      @(negedge clk27);
      lvl = (p <= 128) ? 48 : 40;
      exp_bit = (((p - 1) % 64) < lvl) ? 1 : 0;
      check($sformatf("pwm_pos%0d", p), int'(dac_out), exp_bit);
      if (p == 80) drive(4'hF, 4'h0, 4'hA, 4'hA, 4'hA, 4'hA);
    end

    // Volume glitch rejection and volOnly.
    drive(4'b0001, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0);
    cycles(40);
    check("glitch_base", int'(mix_level), 5);
    for (int i = 0; i < 60; i++) begin
      vol1 = (i % 2 == 0) ? 4'hF : 4'h0;
      cycles(1);
    end
    check("glitch_rejected", int'(mix_level), 5);
    drive(4'b0000, 4'b0001, 4'h7, 4'h0, 4'h0, 4'h0);
    cycles(40);
    check("volonly_ch1", int'(mix_level), 7);

    // Randomized phase; the scoreboard checks every strobe.
    for (int s = 0; s < 40; s++) begin
      seg_len = $urandom_range(1, 25);
      glitch  = ($urandom_range(0, 4) == 0);
      drive(4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      mode = ($urandom_range(0, 3) == 0) ? ~mode : mode;
      mute = ($urandom_range(0, 5) == 0);
      peak_clr = ($urandom_range(0, 3) == 0);
      cycles(1);
      peak_clr = 1'b0;
      for (int i = 0; i < seg_len; i++) begin
        if (glitch) begin
          vol1 = 4'($urandom_range(0, 15));
          vol3 = 4'($urandom_range(0, 15));
        end
        cycles(1);
      end
    end

    drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    cycles(40);
    check("no_pending_samples", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pokey_mixer_dac.md
Name: pokey_mixer_dac

Overview:
- Downstream stage of pokeyaudio. Consumes the four 1-bit channel outputs (audio1..4) and their 4-bit volumes (vol1..4).
- Synchronises them into the 27 MHz domain, mixes them into one 6-bit level, and drives a single header pin through a 1-bit DAC modulator.
- Modulator is selectable: first-order sigma-delta or 64-step PWM.
- Also provides a peak-level meter for ChipScope and debug headers.

Parameters:
SAMPLE_DIV, 15, clk27 cycles per mix sample (27 MHz/15 = 1.8 MHz, close to the clk179 rate); legal range 2..255.
SYNC_STAGES, 2, synchroniser depth on all inputs; legal 2..3.

Ports:
clk27  in  1  27 MHz system clock (CLK_27MHZ_FPGA); all logic on its posedge.
init_L  in  1  asynchronous active-low reset.
audio1..audio4  in  1 each  channel bits from pokeyaudio (clk179 domain).
vol1..vol4  in  4 each  channel volumes from pokeyaudio (clk179 domain).
volOnly  in  4  per-channel force bit (AUDC bit 4); bit n-1 maps to channel n.
mode  in  1  0 = sigma-delta, 1 = PWM.
mute  in  1  forces dac_out low.
peak_clr  in  1  synchronous clear of the peak meter.
dac_out  out  1  modulated audio to the header.
mix_level  out  6  current mixed level, 0..60.
sample_tick  out  1  one-cycle pulse when mix_level updates.
peak  out  6  maximum mix_level since reset or peak_clr.

Behaviour:
- Reset (init_L low, asynchronous): all of the following clear to 0 while init_L is low:
  - dac_out, mix_level, sample_tick, peak
  - sample counter, sigma-delta accumulator, PWM counter, PWM latch
  - all synchroniser flops and held volumes
- Release is synchronous: the first active edge is the first clk27 posedge with init_L high.
- Synchronisers:
  - Each audio bit, volOnly bit, mode, mute and peak_clr passes through a SYNC_STAGES-deep flop chain.
  - Each vol bus passes through the same chain.
  - Held volume volq_n updates only when the last two synchroniser stages of that bus are equal, so bus-skew glitches are rejected. Otherwise volq_n keeps its old value.
- Channel contribution: c_n = (audio_sync_n | volOnly_sync_n) ? volq_n : 0.
- Sample counter:
  - Counts 0..SAMPLE_DIV-1 and wraps to 0.
  - sample_tick is a registered output, high for exactly the one cycle after the counter equals SAMPLE_DIV-1.
  - In that same cycle mix_level <= c1+c2+c3+c4, zero-extended to 6 bits. Maximum is 60; no saturation is needed.
- Latency: an audio or volOnly edge reaches mix_level at the first sample_tick occurring at least SYNC_STAGES+1 cycles after the edge.
- Peak meter:
  - On sample_tick, if the new mix_level > peak, then peak <= new mix_level.
  - peak_clr_sync high sets peak <= 0. If peak_clr_sync and sample_tick coincide, peak <= new mix_level (clear, then compare).
- Sigma-delta (mode_sync = 0), updates every clk27:
  - acc[6:0] <= {1'b0, acc[5:0]} + mix_level.
  - dac_out <= carry of that add (bit 6 of the new sum).
  - Ones density is mix_level/64.
- PWM (mode_sync = 1):
  - 6-bit pwmcnt increments every clk27 and wraps 63 -> 0.
  - pwmlvl <= mix_level only when pwmcnt = 63, so the duty cycle never changes mid-period.
  - dac_out <= (pwmcnt < pwmlvl).
- Mode switch: on any change of mode_sync, for one cycle, clear acc and pwmcnt to 0, load pwmlvl <= mix_level, and drive dac_out <= 0. Resume normally on the next cycle.
- Mute:
  - While mute_sync = 1, dac_out = 0 and acc and pwmcnt hold their values.
  - mix_level, sample_tick and peak keep updating.
  - On unmute, modulation resumes from the held state with no extra cycle.
- Reset mid-operation aborts everything immediately; no partial sample is emitted after release.

Test Plan:
- Reset: hold init_L low with audio/vol active -> dac_out, mix_level, peak, sample_tick all 0. After release with all inputs 0, the first sample_tick arrives at cycle SAMPLE_DIV (15) and mix_level = 0.
- Mixing: audio1..4 = 1, vol = 15,15,15,15 -> mix_level = 60 and peak = 60. Then audio3 = 0 -> mix_level = 45 at the next qualifying tick while peak stays 60. Then peak_clr pulse -> peak = 45 at the next tick.
- Sigma-delta: mix_level held at 32, mode = 0 -> dac_out alternates 0,1 every cycle with exactly 32 ones per 64 cycles. mix_level 60 -> 60 ones per 64 cycles.
- PWM: mix_level 16, mode = 1 -> dac_out high for 16 consecutive cycles per 64-cycle period. A change to 40 mid-period has no effect until after pwmcnt = 63, then 40 high per period.
- Vol glitch and volOnly: vol1 toggles 0 <-> 15 on alternate clk27 cycles -> volq1 never changes. volOnly = 4'b0001, audio1 = 0, vol1 = 7 -> mix_level = 7.
- Mute and mode switch: assert mute during sigma-delta -> dac_out 0 within SYNC_STAGES+1 cycles. Toggle mode -> one forced-0 cycle on dac_out, then PWM pattern starting from pwmcnt = 0.
